// File: rtl/logic_gate_unit_if.sv
// Operand/result stream bundle for logic_gate_unit: operand beats flow in,
// results flow out, each side under its own valid/ready handshake.
interface logic_gate_unit_if #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
);
  localparam int CW = $clog2(ACC_LEN) + 1;

  // Handshake: a beat/result transfers on a rising edge where valid && ready;
  // once valid is raised the producer holds it and its payload until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CW-1:0]    beat_cnt;

  modport master (
    output in_valid, a, b, op, acc_mode, in_last, out_ready,
    input  in_ready, out_valid, y, beat_cnt
  );

  modport slave (
    input  in_valid, a, b, op, acc_mode, in_last, out_ready,
    output in_ready, out_valid, y, beat_cnt
  );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: one of eight gate functions applied per beat
// or reduced across a group of up to ACC_LEN beats, inverted once at the output.
module logic_gate_unit #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  logic_gate_unit_if.slave  bus,
  output logic [1:0]        dbg_state,
  output logic              dbg_mode
);
  localparam int CW = $clog2(ACC_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept;
  logic emit;
  logic open_grp;
  logic [CW-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] base_fn(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = x & z;
      2'b01:   r = x | z;
      2'b10:   r = x ^ z;
      default: r = x;
    endcase
    return r;
  endfunction

  // Reduction folds the raw base value; inversion is applied only at y.
  function automatic logic [WIDTH-1:0] fold_fn(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] f;
    case (sel)
      2'b00:   f = acc & r;
      2'b01:   f = acc | r;
      2'b10:   f = acc ^ r;
      default: f = r;
    endcase
    return f;
  endfunction

  assign bus.in_ready  = (state_q != OUT) || bus.out_ready;
  assign bus.out_valid = (state_q == OUT);
  assign bus.y         = op_q[2] ? ~acc_q : acc_q;
  assign bus.beat_cnt  = cnt_q;
  assign dbg_state     = state_q;
  assign dbg_mode      = mode_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign emit     = (state_q == OUT) && bus.out_ready;
  // A beat accepted in IDLE, or in OUT alongside the emit, starts a new result.
  assign open_grp = accept && (state_q != ACCUM);
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (open_grp) begin
      acc_d  = base_fn(bus.op[1:0], bus.a, bus.b);
      op_d   = bus.op;
      mode_d = bus.acc_mode;
      if (bus.acc_mode) begin
        cnt_d   = CW'(1);
        state_d = (bus.in_last || (ACC_LEN == 1)) ? OUT : ACCUM;
      end else begin
        cnt_d   = '0;
        state_d = OUT;
      end
    end else if ((state_q == ACCUM) && accept) begin
      acc_d = fold_fn(op_q[1:0], acc_q, base_fn(op_q[1:0], bus.a, bus.b));
      cnt_d = cnt_inc;
      if (bus.in_last || (cnt_inc == CW'(ACC_LEN))) begin
        state_d = OUT;
      end
    end else if (emit) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: directed literal cases plus randomized traffic
// against a group-level reference model, checked every falling edge.
module tb_logic_gate_unit;
  localparam int W       = 8;
  localparam int ACC_LEN = 4;
  localparam int CW      = $clog2(ACC_LEN) + 1;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic dbg_mode;

  logic_gate_unit_if #(.WIDTH(W), .ACC_LEN(ACC_LEN)) bus ();

  logic_gate_unit #(.WIDTH(W), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state),
    .dbg_mode(dbg_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  logic lit_on = 1'b1;
  logic [CW+W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: keeps the open group's beats and derives each result
  // from per-bit counts of ones across the whole group.
  logic          m_out_valid = 1'b0;
  logic [W-1:0]  m_y = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          grp_open = 1'b0;
  logic [2:0]    grp_op = '0;
  logic [W-1:0]  grp_a[$];
  logic [W-1:0]  grp_b[$];

  function automatic logic [W-1:0] beat_val(input logic [1:0] sel, input logic [W-1:0] x, input logic [W-1:0] z);
    case (sel)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return x;
    endcase
  endfunction

  function automatic logic [W-1:0] group_result();
    logic [W-1:0] v;
    logic [W-1:0] r;
    int n;
    int ones;
    n = grp_a.size();
    v = '0;
    for (int j = 0; j < W; j++) begin
      ones = 0;
      for (int i = 0; i < n; i++) begin
        r = beat_val(grp_op[1:0], grp_a[i], grp_b[i]);
        ones += int'(r[j]);
      end
      case (grp_op[1:0])
        2'b00:   v[j] = (ones == n);
        2'b01:   v[j] = (ones != 0);
        2'b10:   v[j] = ones[0];
        default: v[j] = grp_a[n-1][j];
      endcase
    end
    return grp_op[2] ? ~v : v;
  endfunction

  task automatic close_group(input logic is_acc);
    m_y         = group_result();
    m_out_valid = 1'b1;
    m_cnt       = is_acc ? CW'(grp_a.size()) : '0;
    grp_open    = 1'b0;
  endtask

  initial begin
    logic rdy;
    logic take;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_out_valid = 1'b0;
        m_y         = '0;
        m_cnt       = '0;
        grp_open    = 1'b0;
        grp_a.delete();
        grp_b.delete();
      end else begin
        rdy  = !m_out_valid || bus.out_ready;
        take = bus.in_valid && rdy;
        if (m_out_valid && bus.out_ready) begin
          m_out_valid = 1'b0;
          m_cnt       = '0;
        end
        if (take) begin
          if (!grp_open) begin
            grp_op = bus.op;
            grp_a.delete();
            grp_b.delete();
            grp_a.push_back(bus.a);
            grp_b.push_back(bus.b);
            if (!bus.acc_mode) close_group(1'b0);
            else begin
              grp_open = 1'b1;
              m_cnt    = CW'(1);
              if (bus.in_last) close_group(1'b1);
            end
          end else begin
            grp_a.push_back(bus.a);
            grp_b.push_back(bus.b);
            m_cnt = CW'(grp_a.size());
            if (bus.in_last || grp_a.size() == ACC_LEN) close_group(1'b1);
          end
        end
      end
    end
  end

  // Compare process: every falling edge, DUT versus model; literal results on emit.
  initial begin
    logic [CW+W-1:0] e;
    forever begin
      @(negedge clk);
      chk("in_ready", bus.in_ready, !m_out_valid || bus.out_ready);
      chk("out_valid", bus.out_valid, m_out_valid);
      chk("beat_cnt", bus.beat_cnt, m_cnt);
      if (m_out_valid) chk("y", bus.y, m_y);
      if (lit_on && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("lit_result", {bus.beat_cnt, bus.y}, e);
        end else begin
          chk("lit_unexpected_emit", 1, 0);
        end
      end
    end
  end

  // Driver: called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [2:0] oo,
                      input logic mm, input logic ll);
    logic rdy;
    logic done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = aa;
    bus.b        = bb;
    bus.op       = oo;
    bus.acc_mode = mm;
    bus.in_last  = ll;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    chk("send_accept", done, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [CW+W-1:0] lit(input int cnt, input logic [W-1:0] v);
    return {CW'(cnt), v};
  endfunction

  initial begin
    logic [W-1:0] sweep_exp[8];
    sweep_exp = '{8'h81, 8'hE7, 8'h66, 8'hC3, 8'h7E, 8'h18, 8'h99, 8'h3C};
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    bus.acc_mode = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Single-mode sweep over all eight functions
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(lit(0, sweep_exp[k]));
      send(8'hC3, 8'hA5, 3'(k), 1'b0, 1'b0);
    end
    idle(2);

    // Full accumulate groups: OR then XNOR over one-hot beats
    exp_q.push_back(lit(4, 8'h0F));
    for (int k = 0; k < 4; k++) send(8'(1 << k), 8'h00, 3'b001, 1'b1, 1'b0);
    exp_q.push_back(lit(4, 8'hF0));
    for (int k = 0; k < 4; k++) send(8'(1 << k), 8'h00, 3'b110, 1'b1, 1'b0);
    idle(2);

    // Early close by in_last
    exp_q.push_back(lit(2, 8'h30));
    send(8'hF0, 8'hF0, 3'b000, 1'b1, 1'b0);
    send(8'h3C, 8'h3C, 3'b000, 1'b1, 1'b1);
    idle(2);

    // Backpressure, then back-to-back release opening a new group
    bus.out_ready = 1'b0;
    exp_q.push_back(lit(0, 8'h55));
    send(8'h5A, 8'h0F, 3'b010, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.a = 8'h11; bus.b = 8'h33; bus.op = 3'b001; bus.acc_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_y_hold", bus.y, 8'h55);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    exp_q.push_back(lit(2, 8'h77));
    send(8'h11, 8'h33, 3'b001, 1'b1, 1'b0);
    chk("b2b_beat_cnt", bus.beat_cnt, 1);
    chk("b2b_out_valid", bus.out_valid, 0);
    send(8'h44, 8'h00, 3'b101, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset mid-OUT with the consumer stalled
    bus.out_ready = 1'b0;
    send(8'hFF, 8'hFF, 3'b000, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 8'h00);
    chk("rst_beat_cnt", bus.beat_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);

    // Reset mid-group discards the partial group
    send(8'hFF, 8'h00, 3'b010, 1'b1, 1'b0);
    send(8'h0F, 8'h00, 3'b010, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rstg_out_valid", bus.out_valid, 0);
    chk("rstg_beat_cnt", bus.beat_cnt, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    exp_q.push_back(lit(4, 8'h04));
    for (int k = 1; k <= 4; k++) send(8'(k), 8'h00, 3'b010, 1'b1, 1'b0);
    idle(3);
    chk("lit_drained", exp_q.size(), 0);
    lit_on = 1'b0;

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.op        = 3'($urandom_range(0, 7));
      bus.acc_mode  = ($urandom_range(0, 3) != 0);
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
